mandelbrot_pixel_packer: RTL
============================

// Module: mandelbrot_pixel_packer
// PURPOSE
//  Downstream stage of the Mandelbrot iteration engine. Sequences the engine one pixel at a time
//  by pulsing its run input, captures each 4-bit iteration count, and packs two pixels per byte.
//  Bytes are buffered in a small FIFO and leave on a valid/ready byte stream to the pin/host interface.
//  Frame-start and frame-end markers are tagged on the stream.
// PARAMETERS
//  FIFO_DEPTH  4  byte entries in output FIFO; power of two, >=2
//  CONTINUOUS  1  1: start the next frame automatically while enable=1; 0: one frame per enable rising edge
// PORTS
//  clk           in   1  clock
//  reset         in   1  synchronous, active-high reset
//  enable        in   1  frame generation allowed
//  eng_run       out  1  one-cycle pulse: engine computes the next pixel
//  eng_running   in   1  engine busy flag
//  eng_ctr       in   4  engine iteration count; valid while eng_running=0
//  eng_finished  in   1  engine frame-complete flag
//  out_data      out  8  packed byte: [3:0]=even pixel, [7:4]=odd pixel
//  out_valid     out  1  out_data valid
//  out_ready     in   1  consumer accepts; transfer when out_valid & out_ready
//  out_first     out  1  qualifies out_data: first byte of a frame
//  out_last      out  1  qualifies out_data: last byte of a frame
//  frame_done    out  1  one-cycle pulse when the out_last byte transfers
//  busy          out  1  FSM not in IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO empty; nibble register cleared; first_pend=1.
//   All outputs 0: eng_run, out_valid, out_data, out_first, out_last, frame_done, busy.
//  FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, PUSH.
//  IDLE -> ISSUE when enable=1 & eng_finished=1.
//   CONTINUOUS=0: additionally requires an enable rising edge since the last frame.
//  ISSUE: eng_run=1 for exactly one cycle when enable=1 & FIFO not full; then -> WAIT_BUSY.
//   If enable=0, stay in ISSUE without pulsing (pause between pixels; frame position kept).
//  WAIT_BUSY -> WAIT_DONE on eng_running=1 (engine takes >=1 cycle to react).
//  WAIT_DONE -> PUSH on eng_running=0. Same cycle: capture eng_ctr into pix; capture eng_finished into last.
//  PUSH, even nibble: store pix in low nibble.
//   last=0 -> ISSUE.
//   last=1 -> push {4'h0,pix} with out_last=1, then -> IDLE (odd-length frame pads high nibble with 0).
//  PUSH, odd nibble: push {pix,low}. out_first = first_pend; first_pend cleared.
//   out_last = last. last=1 -> IDLE, first_pend=1; else -> ISSUE.
//  At most one byte is pushed per pixel; FIFO not-full is checked at ISSUE, so a push never overflows.
//  Byte latency: out_valid rises 1 cycle after the push cycle (registered FIFO output).
//  FIFO: pop on out_valid & out_ready. Push and pop in the same cycle are allowed when full or empty.
//   Empty case: data appears the next cycle; no fall-through.
//  out_data/out_first/out_last are held stable while out_valid=1 & out_ready=0.
//  frame_done pulses in the cycle after the transfer of the byte with out_last=1.
//  enable falling mid-pixel: the current pixel completes and is pushed; the FSM then parks in ISSUE.
//  reset mid-frame: FIFO flushed, partial byte dropped; eng_run=0 from the next cycle.
//   The engine shares reset and re-arms finished=1, so the next frame starts from pixel 0.
//  Back-pressure: out_ready=0 stalls the engine only through FIFO full at ISSUE; no pixel is lost.
// STRUCTURE
//  mandelbrot_pkg: state enum pkr_state_t; NIBBLE_W=4, BYTE_W=8.
//  Sub-module pkr_sync_fifo (WIDTH=10 {last,first,data}, DEPTH=FIFO_DEPTH).
//   Pointers carry an extra wrap bit; registered output.
//  Top level: FSM, nibble register, first/last flag logic.
// TESTING
//  1. Engine model 2x2 frame, counts 1,2,3,4; out_ready=1 -> bytes 0x21 (first=1), 0x43 (last=1); frame_done once.
//  2. out_ready=0, 20-pixel frame -> exactly FIFO_DEPTH bytes queued, eng_run stops.
//     Release out_ready -> all 10 bytes in order, none lost.
//  3. 3-pixel frame with counts 5,6,7 -> bytes 0x65, 0x07 (last=1, high nibble padded).
//  4. enable dropped while eng_running=1 -> that pixel pushed; no further eng_run until enable=1.
//     Stream then resumes with no gap in pixel order.
//  5. reset asserted mid-frame with 2 bytes queued -> out_valid=0 next cycle.
//     Next frame's first byte carries out_first=1.
//  6. CONTINUOUS=1, enable held high -> second frame starts without re-trigger; first byte again has out_first=1.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// ---------------------------------------------------------------------------
// mandelbrot_pkg
//   Shared types for the Mandelbrot pixel packer: FSM state encoding, the
//   beat carried through the output FIFO ({last, first, data}) and a helper
//   that assembles a beat from two iteration-count nibbles.
// ---------------------------------------------------------------------------
package mandelbrot_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    PKR_IDLE      = 3'd0,
    PKR_ISSUE     = 3'd1,
    PKR_WAIT_BUSY = 3'd2,
    PKR_WAIT_DONE = 3'd3,
    PKR_PUSH      = 3'd4
  } pkr_state_t;

  // One FIFO entry: frame markers travel with the byte they qualify.
  typedef struct packed {
    logic              last;
    logic              first;
    logic [BYTE_W-1:0] data;
  } pkr_beat_t;

  localparam int BEAT_W = $bits(pkr_beat_t);

  // Even pixel goes to the low nibble, odd pixel to the high nibble.
  function automatic pkr_beat_t pkr_pack_beat(input logic                last,
                                               input logic                first,
                                               input logic [NIBBLE_W-1:0] hi,
                                               input logic [NIBBLE_W-1:0] lo);
    pkr_beat_t b;
    b.last  = last;
    b.first = first;
    b.data  = {hi, lo};
    return b;
  endfunction

endpackage

// File: rtl/pkr_sync_fifo.sv
// ---------------------------------------------------------------------------
// pkr_sync_fifo
//   Small synchronous FIFO with a registered head. Read/write pointers carry
//   one extra wrap bit so full and empty are distinguished without a counter.
//   The head register is loaded from the post-update pointers, so a word
//   pushed into an empty FIFO shows up one cycle later (no fall-through) and
//   the head is held stable while nobody pops.
// Ports
//   clk, reset       clock, synchronous active-high reset (flushes pointers)
//   push_i           write push_data_i (ignored when full unless popping)
//   push_data_i      word to store
//   pop_i            consume the head word when valid_o=1
//   full_o           no room for another push
//   valid_o          pop_data_o holds a valid head word
//   pop_data_o       head word (zero while empty)
// ---------------------------------------------------------------------------
module pkr_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] head_s;
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i & valid_q;
  // A pop frees the slot in the same cycle, so push is allowed when full.
  assign do_push_s = push_i & (~full_s | do_pop_s);

  // Pointer advance and next head selection.
  always_comb begin
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop_s};
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push_s};
    // The new head is the word being written when it lands in the head slot.
    if (do_push_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_s = push_data_i;
    end else begin
      head_s = mem_q[rd_ptr_d[AW-1:0]];
    end
    if (rd_ptr_d == wr_ptr_d) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      valid_d = 1'b1;
      data_d  = head_s;
    end
  end

  // Pointer and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Storage array; contents are don't-care until a pointer makes them valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign full_o     = full_s;
  assign valid_o    = valid_q;
  assign pop_data_o = data_q;

endmodule

// File: rtl/mandelbrot_pixel_packer.sv
// ---------------------------------------------------------------------------
// mandelbrot_pixel_packer
//   Drives the Mandelbrot iteration engine one pixel at a time, captures each
//   4-bit iteration count and packs two pixels per byte (even pixel in the low
//   nibble). Bytes go through a small FIFO onto a valid/ready stream tagged
//   with frame-start / frame-end markers.
// Ports
//   clk, reset     clock, synchronous active-high reset
//   enable         frame generation allowed (low pauses between pixels)
//   eng_run        one-cycle pulse: engine computes the next pixel
//   eng_running    engine busy flag
//   eng_ctr        engine iteration count, valid while eng_running=0
//   eng_finished   engine frame-complete flag
//   out_data       packed byte [3:0]=even pixel, [7:4]=odd pixel
//   out_valid      out_data valid
//   out_ready      consumer accepts (transfer on out_valid & out_ready)
//   out_first      out_data is the first byte of a frame
//   out_last       out_data is the last byte of a frame
//   frame_done     one-cycle pulse after the out_last byte transfers
//   busy           FSM active or FIFO holding data
// ---------------------------------------------------------------------------
module mandelbrot_pixel_packer
  import mandelbrot_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                eng_run,
  input  logic                eng_running,
  input  logic [NIBBLE_W-1:0] eng_ctr,
  input  logic                eng_finished,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_first,
  output logic                out_last,
  output logic                frame_done,
  output logic                busy
);

  pkr_state_t          state_q, state_d;
  logic [NIBBLE_W-1:0] pix_q, pix_d;       // count of the pixel just finished
  logic                last_q, last_d;     // that pixel ends the frame
  logic [NIBBLE_W-1:0] low_q, low_d;       // parked even pixel
  logic                odd_q, odd_d;       // next captured pixel is the odd one
  logic                first_pend_q, first_pend_d;
  logic                armed_q, armed_d;   // enable rose since the last frame
  logic                en_prev_q;
  logic                eng_run_q, eng_run_d;
  logic                frame_done_q;

  logic                en_rise_s;
  logic                start_s;
  logic                push_s;
  pkr_beat_t           push_beat_s;
  pkr_beat_t           fifo_beat_s;
  logic                fifo_full_s;
  logic                fifo_valid_s;
  logic                xfer_s;

  assign en_rise_s = enable & ~en_prev_q;
  // One-shot mode needs a fresh enable edge; continuous mode restarts freely.
  assign start_s   = enable & eng_finished & (CONTINUOUS | armed_q | en_rise_s);
  assign xfer_s    = fifo_valid_s & out_ready;

  // Next-state, nibble packing and FIFO push decode.
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    last_d       = last_q;
    low_d        = low_q;
    odd_d        = odd_q;
    first_pend_d = first_pend_q;
    armed_d      = armed_q | en_rise_s;
    eng_run_d    = 1'b0;
    push_s       = 1'b0;
    push_beat_s  = '0;

    case (state_q)
      PKR_IDLE: begin
        if (start_s) begin
          state_d = PKR_ISSUE;
          armed_d = 1'b0;
        end else begin
          state_d = PKR_IDLE;
        end
      end

      PKR_ISSUE: begin
        // Checking for room here guarantees the coming push cannot overflow.
        if (enable && !fifo_full_s) begin
          eng_run_d = 1'b1;
          state_d   = PKR_WAIT_BUSY;
        end else begin
          state_d   = PKR_ISSUE;
        end
      end

      PKR_WAIT_BUSY: begin
        if (eng_running) begin
          state_d = PKR_WAIT_DONE;
        end else begin
          state_d = PKR_WAIT_BUSY;
        end
      end

      PKR_WAIT_DONE: begin
        if (!eng_running) begin
          pix_d   = eng_ctr;
          last_d  = eng_finished;
          state_d = PKR_PUSH;
        end else begin
          state_d = PKR_WAIT_DONE;
        end
      end

      PKR_PUSH: begin
        if (!odd_q) begin
          low_d = pix_q;
          if (last_q) begin
            // Odd-length frame: flush the lone pixel with a zero high nibble.
            push_s       = 1'b1;
            push_beat_s  = pkr_pack_beat(1'b1, first_pend_q, 4'h0, pix_q);
            first_pend_d = 1'b1;
            odd_d        = 1'b0;
            state_d      = PKR_IDLE;
          end else begin
            odd_d   = 1'b1;
            state_d = PKR_ISSUE;
          end
        end else begin
          push_s      = 1'b1;
          push_beat_s = pkr_pack_beat(last_q, first_pend_q, pix_q, low_q);
          odd_d       = 1'b0;
          if (last_q) begin
            first_pend_d = 1'b1;
            state_d      = PKR_IDLE;
          end else begin
            first_pend_d = 1'b0;
            state_d      = PKR_ISSUE;
          end
        end
      end

      default: begin
        state_d = PKR_IDLE;
      end
    endcase
  end

  // FSM, pixel/nibble registers and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PKR_IDLE;
      pix_q        <= 4'h0;
      last_q       <= 1'b0;
      low_q        <= 4'h0;
      odd_q        <= 1'b0;
      first_pend_q <= 1'b1;
      armed_q      <= 1'b0;
      en_prev_q    <= 1'b0;
      eng_run_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      last_q       <= last_d;
      low_q        <= low_d;
      odd_q        <= odd_d;
      first_pend_q <= first_pend_d;
      armed_q      <= armed_d;
      en_prev_q    <= enable;
      eng_run_q    <= eng_run_d;
      frame_done_q <= xfer_s & fifo_beat_s.last;
    end
  end

  pkr_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (push_beat_s),
    .pop_i       (out_ready),
    .full_o      (fifo_full_s),
    .valid_o     (fifo_valid_s),
    .pop_data_o  (fifo_beat_s)
  );

  assign eng_run    = eng_run_q;
  assign out_valid  = fifo_valid_s;
  assign out_data   = fifo_beat_s.data;
  assign out_first  = fifo_beat_s.first;
  assign out_last   = fifo_beat_s.last;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != PKR_IDLE) | fifo_valid_s;

endmodule
